// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM controller for the multicycle ARM datapath
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // One bundle of every FSM-driven datapath control, kept registered as a unit
  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regwrite;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  // Instr carries bits [31:12] of the instruction word
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  state_t     state;
  state_t     state_nx;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_o;
  logic [3:0] flags;
  logic       condex;
  logic       condexr;
  logic       condexr_nx;
  logic [2:0] dp_alu;
  logic       dp_nowrite;
  logic       dp_s;
  logic       dp_arith;
  logic       exec_state;
  logic       ld_nz;
  logic       ld_cv;

  // Moore output table for a given state; cex is the latched condition result
  function automatic ctrl_t ctrl_for(input state_t s, input logic cex,
                                     input logic [2:0] aluc, input logic nowrite,
                                     input logic rd_pc);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.pcwrite   = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_MEMADR: c.alusrcb = 2'b01;
      S_MEMRD:  c.adrsrc  = 1'b1;
      S_MEMWR: begin
        c.adrsrc   = 1'b1;
        c.memwrite = cex;
      end
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = cex;
        c.pcwrite   = cex & rd_pc;
      end
      S_EXECR: c.alucontrol = aluc;
      S_EXECI: begin
        c.alusrcb    = 2'b01;
        c.alucontrol = aluc;
      end
      S_ALUWB: begin
        c.regwrite = cex & ~nowrite;
        c.pcwrite  = cex & ~nowrite & rd_pc;
      end
      S_BRANCH: begin
        c.alusrcb   = 2'b01;
        c.resultsrc = 2'b10;
        c.pcwrite   = cex;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Evaluate the condition field against the stored NZCV flags
  always_comb begin
    condex = 1'b0;
    case (cond)
      4'h0:    condex = flags[2];
      4'h1:    condex = ~flags[2];
      4'h2:    condex = flags[1];
      4'h3:    condex = ~flags[1];
      4'h4:    condex = flags[3];
      4'h5:    condex = ~flags[3];
      4'h6:    condex = flags[0];
      4'h7:    condex = ~flags[0];
      4'h8:    condex = flags[1] & ~flags[2];
      4'h9:    condex = ~flags[1] | flags[2];
      4'hA:    condex = (flags[3] == flags[0]);
      4'hB:    condex = (flags[3] != flags[0]);
      4'hC:    condex = ~flags[2] & (flags[3] == flags[0]);
      4'hD:    condex = flags[2] | (flags[3] != flags[0]);
      4'hE:    condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // Data-processing decode; unrecognised commands become a silent ADD with no flag effect
  always_comb begin
    dp_alu     = ALU_ADD;
    dp_nowrite = 1'b0;
    dp_s       = funct[0];
    dp_arith   = 1'b0;
    case (funct[4:1])
      4'b0100: begin dp_alu = ALU_ADD; dp_arith = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; dp_arith = 1'b1; end
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b1010: begin
        dp_alu     = ALU_SUB;
        dp_nowrite = 1'b1;
        dp_s       = 1'b1;
        dp_arith   = 1'b1;
      end
      default: begin
        dp_alu     = ALU_ADD;
        dp_nowrite = 1'b1;
        dp_s       = 1'b0;
      end
    endcase
  end

  // Next-state selection from the current step and the decoded instruction class
  always_comb begin
    state_nx = S_FETCH;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_nx = S_MEMADR;
          2'b00:   state_nx = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: state_nx = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nx = S_MEMWB;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  state_nx = S_FETCH;
      S_EXECR:  state_nx = S_ALUWB;
      S_EXECI:  state_nx = S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  // The branch step needs the condition result in the same edge that latches it
  assign condexr_nx = (state == S_DECODE) ? condex : condexr;
  assign exec_state = (state == S_EXECR) || (state == S_EXECI);
  assign ld_nz      = exec_state & dp_s & condexr;
  assign ld_cv      = ld_nz & dp_arith;

  // State, flags, latched condition and registered controls for the next step
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      flags   <= 4'b0000;
      condexr <= 1'b0;
      ctrl_q  <= ctrl_for(S_FETCH, 1'b0, ALU_ADD, 1'b0, 1'b0);
    end else begin
      state   <= state_nx;
      condexr <= condexr_nx;
      ctrl_q  <= ctrl_for(state_nx, condexr_nx, dp_alu, dp_nowrite, rd == 4'hF);
      if (ld_nz) flags[3:2] <= ALUFlags[3:2];
      if (ld_cv) flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Reset overrides the registered controls so no write escapes during the reset cycle
  always_comb begin
    ctrl_o = ctrl_q;
    if (!reset) begin
      ctrl_o          = ctrl_for(S_FETCH, 1'b0, ALU_ADD, 1'b0, 1'b0);
      ctrl_o.pcwrite  = 1'b0;
      ctrl_o.irwrite  = 1'b0;
      ctrl_o.regwrite = 1'b0;
      ctrl_o.memwrite = 1'b0;
    end
  end

  assign PCWrite    = ctrl_o.pcwrite;
  assign AdrSrc     = ctrl_o.adrsrc;
  assign MemWrite   = ctrl_o.memwrite;
  assign IRWrite    = ctrl_o.irwrite;
  assign ResultSrc  = ctrl_o.resultsrc;
  assign ALUSrcA    = ctrl_o.alusrca;
  assign ALUSrcB    = ctrl_o.alusrcb;
  assign ALUControl = ctrl_o.alucontrol;
  assign RegWrite   = ctrl_o.regwrite;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized scoreboard bench for multicycle_controller
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .RegWrite(RegWrite), .State(State)
  );

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4;
  localparam int MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;

  logic [20:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_flags;
  logic [19:0] prev_ir;

  // ARM condition table over architectural flags {N,Z,C,V}
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction semantics: ALU op, whether the result is discarded, S, and arithmetic class
  task automatic dp_decode(input logic [5:0] f, output logic [2:0] aluc, output logic nowr,
                           output logic s, output logic arith);
    s = f[0]; nowr = 1'b0; arith = 1'b0; aluc = 3'd0;
    case (f[4:1])
      4'b0100: begin aluc = 3'd0; arith = 1'b1; end
      4'b0010: begin aluc = 3'd1; arith = 1'b1; end
      4'b0000: aluc = 3'd2;
      4'b1100: aluc = 3'd3;
      4'b1010: begin aluc = 3'd1; nowr = 1'b1; s = 1'b1; arith = 1'b1; end
      default: begin aluc = 3'd0; nowr = 1'b1; end
    endcase
  endtask

  // Expected output vector for one step of an instruction
  function automatic logic [20:0] exp_for(input int st, input logic cex, input logic [2:0] aluc,
                                          input logic nowr, input logic [19:0] ir,
                                          input logic rst_low);
    logic pcw, adr, mw, irw, asa, rw, rd15;
    logic [1:0] rs, asb, op;
    logic [2:0] ac;
    pcw = 0; adr = 0; mw = 0; irw = 0; asa = 0; rw = 0; rs = 0; asb = 0; ac = 0;
    rd15 = (ir[3:0] == 4'hF);
    op = ir[15:14];
    if (rst_low) begin
      asa = 1; asb = 2'b10; rs = 2'b10;
    end else begin
      case (st)
        FETCH:  begin irw = 1; pcw = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
        DECODE: begin asa = 1; asb = 2'b10; rs = 2'b10; end
        MEMADR: asb = 2'b01;
        MEMRD:  adr = 1;
        MEMWR:  begin adr = 1; mw = cex; end
        MEMWB:  begin rs = 2'b01; rw = cex; pcw = cex & rd15; end
        EXECR:  ac = aluc;
        EXECI:  begin asb = 2'b01; ac = aluc; end
        ALUWB:  begin rw = cex & ~nowr; pcw = cex & ~nowr & rd15; end
        BRANCH: begin asb = 2'b01; rs = 2'b10; pcw = cex; end
        default: ;
      endcase
    end
    return {4'(st), pcw, adr, mw, irw, rs, asa, asb, ac, op, (op == 2'b01), (op == 2'b10), rw};
  endfunction

  // Issue one instruction step by step; af<0 means random ALUFlags, abort_at is the step to reset in
  task automatic run_instr(input logic [31:0] ins, input int af, input int abort_at);
    logic [19:0] ir;
    logic [1:0]  op;
    logic [5:0]  f;
    logic        cex, nowr, s, arith;
    logic [2:0]  aluc;
    logic [3:0]  afv;
    int          seq[$];
    ir = ins[31:12];
    op = ir[15:14];
    f  = ir[13:8];
    cex = cond_holds(ir[19:16], m_flags);
    dp_decode(f, aluc, nowr, s, arith);
    seq.push_back(FETCH);
    seq.push_back(DECODE);
    if (op == 2'b01) begin
      seq.push_back(MEMADR);
      if (f[0]) begin seq.push_back(MEMRD); seq.push_back(MEMWB); end
      else seq.push_back(MEMWR);
    end else if (op == 2'b00) begin
      seq.push_back(f[5] ? EXECI : EXECR);
      seq.push_back(ALUWB);
    end else if (op == 2'b10) begin
      seq.push_back(BRANCH);
    end
    foreach (seq[i]) begin
      Instr = (i == 0) ? prev_ir : ir;
      afv = (af < 0) ? 4'($urandom) : 4'(af);
      ALUFlags = afv;
      if (i == abort_at) begin
        reset = 1'b0;
        exp_q.push_back(exp_for(seq[i], cex, aluc, nowr, Instr, 1'b1));
        @(posedge clk); #1;
        reset = 1'b1;
        m_flags = 4'b0000;
        prev_ir = Instr;
        return;
      end
      exp_q.push_back(exp_for(seq[i], cex, aluc, nowr, Instr, 1'b0));
      @(posedge clk); #1;
      if ((seq[i] == EXECR || seq[i] == EXECI) && s && cex) begin
        m_flags[3:2] = afv[3:2];
        if (arith) m_flags[1:0] = afv[1:0];
      end
    end
    prev_ir = ir;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cond, rd, rn, cmd;
    logic [1:0] op;
    logic [5:0] f;
    int         k;
    cond = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
    op   = 2'($urandom);
    rd   = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
    rn   = 4'($urandom);
    f    = 6'($urandom);
    if (op == 2'b00) begin
      k = $urandom_range(0, 5);
      case (k)
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        4: cmd = 4'b1010;
        default: cmd = 4'b0110;
      endcase
      f[4:1] = cmd;
      if (k == 5) f[0] = 1'b0;
    end
    return {cond, op, f, rn, rd, 12'($urandom)};
  endfunction

  // Monitor: compare the DUT outputs against the oldest expected vector
  always @(negedge clk) begin
    logic [20:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL step t=%0t exp_state=%0d got=%h exp=%h", $time, e[20:17], a, e);
      end
    end
  end

  initial begin
    int ab;
    reset = 1'b0; Instr = '0; ALUFlags = '0; m_flags = '0; prev_ir = '0;
    @(posedge clk); #1;
    repeat (3) begin
      exp_q.push_back(exp_for(FETCH, 1'b0, 3'd0, 1'b0, Instr, 1'b1));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    run_instr(32'hE0821003, -1, -1);
    run_instr(32'hE5921004, -1, -1);
    run_instr(32'hE5821004, -1, -1);
    run_instr(32'hE0500000, 4'b0100, -1);
    run_instr(32'h0A000000, -1, -1);
    run_instr(32'hE0500000, 4'b0000, -1);
    run_instr(32'h0A000000, -1, -1);
    run_instr(32'hE1500000, 4'b0110, -1);
    run_instr(32'h0A000000, -1, -1);
    run_instr(32'hE28FF000, -1, -1);
    run_instr(32'hEC000000, -1, -1);
    run_instr(32'hE5821004, -1, 3);
    run_instr(32'h0A000000, -1, -1);
    repeat (300) begin
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(rand_instr(), -1, ab);
    end
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
